flag_seq_unit: RTL and testbench
================================

# flag_seq_unit

Status-flag sequencer that sits on the far side of the processor ALU: it consumes the ALU's flag-control outputs (shift-carry, parity, their enable and clear strobes, and the result byte), holds the architectural flags in registers, and feeds them back to the ALU as the carry-in and parity-in of the next operation. It also provides a small LIFO flag stack so the controller can save and restore flag context around subroutine calls and interrupts.

## Interface
- STACK_DEPTH, 4, number of saved flag entries (≥2)
- CNT_W, $clog2(STACK_DEPTH+1), width of stack occupancy count
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flag_we  input  1  commit this cycle's ALU flag outputs (instruction retires)
- sc_o  input  1  ALU shift-carry out
- sc_en  input  1  ALU shift-carry load strobe
- sc_clr  input  1  ALU shift-carry clear strobe
- pari  input  1  ALU parity result
- pari_en  input  1  ALU parity load strobe
- pari_clr  input  1  ALU parity clear strobe
- rslt  input  8  ALU result byte (zero detect)
- push  input  1  save {zf, pf, cf} onto stack
- pop  input  1  restore flags from top of stack
- err_clr  input  1  clear sticky stack error
- sc_i  output  1  registered carry flag, to ALU sc_i
- pari_in  output  1  registered parity flag, to ALU pari_in
- zero  output  1  registered zero flag
- stk_cnt  output  CNT_W  entries currently stacked
- stk_full  output  1  stk_cnt == STACK_DEPTH
- stk_empty  output  1  stk_cnt == 0
- stk_err  output  1  sticky overflow/underflow/conflict flag

## Operation
- Flags cf (sc_i), pf (pari_in), zf (zero) are registers; outputs drive directly from them, no combinational path from inputs.
- Flag update when flag_we=1 and no valid pop this cycle:
  - cf: sc_clr → 0; else sc_en → sc_o; else hold. Clear beats enable.
  - pf: pari_clr → 0; else pari_en → pari; else hold. Clear beats enable.
  - zf: (rslt == 8'h00).
- flag_we=0: all flags hold; strobes ignored.
- Push (push=1, pop=0): if not full, write current pre-update {zf,pf,cf} to entry stk_cnt, stk_cnt+1; flag update from flag_we still applies same cycle. If full: stack unchanged, stk_err←1.
- Pop (pop=1, push=0): if not empty, flags ← entry stk_cnt-1, stk_cnt-1; pop overrides flag_we that cycle. If empty: stack unchanged, stk_err←1, flag_we update applies normally.
- push=1 and pop=1 together: stack and count unchanged, stk_err←1, flag_we update applies normally.
- stk_err sticky; cleared by err_clr=1 only. Same-cycle error event and err_clr: error set wins.
- Stack storage: STACK_DEPTH × 3 bits, indexed by stk_cnt; contents above stk_cnt are don't-care.

## Timing
- All state updates on rising clk; effect visible on outputs the following cycle (1-cycle latency). ALU sees new sc_i/pari_in on the instruction after the committing one.
- Reset (rst_n low, any time, asynchronous): cf=0, pf=0, zf=0, stk_cnt=0, stk_empty=1, stk_full=0, stk_err=0. Stacked entries lost. Reset mid-push/pop aborts the operation; first edge after rst_n deasserts behaves as from empty.
- stk_full/stk_empty decode from registered stk_cnt; update same edge as stk_cnt.
- Back-to-back push/pop on consecutive cycles fully supported; no bubbles.

## Test plan
- Reset then flag_we=1, sc_en=1, sc_o=1, pari_en=1, pari=1, rslt=8'h00 → next cycle sc_i=1, pari_in=1, zero=1; then sc_clr=1 with sc_en=1, sc_o=1, rslt=8'h5A → sc_i=0, pari_in=1 (hold), zero=0.
- flag_we=0 with all strobes asserted, rslt=0 → flags unchanged for 3 cycles.
- Set flags {zf,pf,cf}=3'b011, push; change to 3'b100; pop → flags 3'b011, stk_cnt 1→0, stk_empty=1, pop cycle's flag_we (sc_en=1, sc_o=0) ignored.
- Push 5 times with STACK_DEPTH=4 → stk_cnt=4, stk_full=1, stk_err=1 after 5th; pop 4 times returns entries in reverse order; 5th pop → stk_err stays 1, flags unchanged, cnt=0; err_clr → stk_err=0.
- push=1 and pop=1 with stk_cnt=2 and flag_we sc_en=1, sc_o=1 → stk_cnt stays 2, stk_err=1, sc_i=1.
- Push 2 entries, assert rst_n=0 mid-cycle → immediately all outputs at reset values without clk edge; after release pop → stk_err=1, flags 0.

Source files
------------

// File: rtl/flag_seq_unit.sv
// Status-flag sequencer: holds ALU carry/parity/zero flags, feeds carry and parity back
// to the ALU, and keeps a small LIFO of saved {zf, pf, cf} contexts.
module flag_seq_unit #(
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned CNT_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flag_we,
   input  logic             sc_o,
   input  logic             sc_en,
   input  logic             sc_clr,
   input  logic             pari,
   input  logic             pari_en,
   input  logic             pari_clr,
   input  logic [7:0]       rslt,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   output logic             sc_i,
   output logic             pari_in,
   output logic             zero,
   output logic [CNT_W-1:0] stk_cnt,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

   typedef struct packed {
      logic zf;
      logic pf;
      logic cf;
   } flags_t;

   flags_t             flags_q, flags_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               err_q, err_d;
   logic               do_push, do_pop, err_evt;
   flags_t             stack_mem [STACK_DEPTH];

   // Next-state: a successful pop restores flags and overrides the ALU commit.
   always_comb begin
      flags_d = flags_q;
      cnt_d   = cnt_q;
      do_push = push & ~pop & ~full_q;
      do_pop  = pop & ~push & ~empty_q;
      err_evt = (push & pop) | (push & ~pop & full_q) | (pop & ~push & empty_q);

      if (do_pop) begin
         flags_d = stack_mem[IDX_W'(cnt_q - CNT_W'(1))];
         cnt_d   = cnt_q - CNT_W'(1);
      end else begin
         if (flag_we) begin
            if (sc_clr)
               flags_d.cf = 1'b0;
            else if (sc_en)
               flags_d.cf = sc_o;
            if (pari_clr)
               flags_d.pf = 1'b0;
            else if (pari_en)
               flags_d.pf = pari;
            flags_d.zf = (rslt == 8'h00);
         end
         if (do_push)
            cnt_d = cnt_q + CNT_W'(1);
      end

      full_d  = (cnt_d == CNT_W'(STACK_DEPTH));
      empty_d = (cnt_d == CNT_W'(0));
      err_d   = err_evt | (err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   // Saved context is the pre-update flag value; entries above cnt are don't-care.
   always_ff @(posedge clk) begin
      if (do_push)
         stack_mem[IDX_W'(cnt_q)] <= flags_q;
   end

   assign sc_i      = flags_q.cf;
   assign pari_in   = flags_q.pf;
   assign zero      = flags_q.zf;
   assign stk_cnt   = cnt_q;
   assign stk_full  = full_q;
   assign stk_empty = empty_q;
   assign stk_err   = err_q;

endmodule

// File: tb/tb_flag_seq_unit.sv
// Scoreboard bench for flag_seq_unit: a queue-based reference model predicts the
// post-edge outputs of every applied cycle; a monitor compares them after each edge.
module tb_flag_seq_unit;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flag_we, sc_o, sc_en, sc_clr, pari, pari_en, pari_clr;
   logic [7:0]    rslt;
   logic          push, pop, err_clr;
   logic          sc_i, pari_in, zero, stk_full, stk_empty, stk_err;
   logic [CW-1:0] stk_cnt;

   typedef struct packed {
      logic       we, sc_o, sc_en, sc_clr, pari, pari_en, pari_clr;
      logic [7:0] rslt;
      logic       push, pop, err_clr;
   } stim_t;

   typedef struct packed {
      logic          cf, pf, zf;
      logic [CW-1:0] cnt;
      logic          full, empty, err;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state
   logic       m_cf, m_pf, m_zf, m_err;
   logic [2:0] m_stk[$];

   flag_seq_unit #(.STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .sc_o(sc_o), .sc_en(sc_en),
      .sc_clr(sc_clr), .pari(pari), .pari_en(pari_en), .pari_clr(pari_clr),
      .rslt(rslt), .push(push), .pop(pop), .err_clr(err_clr),
      .sc_i(sc_i), .pari_in(pari_in), .zero(zero), .stk_cnt(stk_cnt),
      .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t actual();
      exp_t a;
      a.cf = sc_i; a.pf = pari_in; a.zf = zero; a.cnt = stk_cnt;
      a.full = stk_full; a.empty = stk_empty; a.err = stk_err;
      return a;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.cf = m_cf; e.pf = m_pf; e.zf = m_zf;
      e.cnt   = CW'(m_stk.size());
      e.full  = (m_stk.size() == DEPTH);
      e.empty = (m_stk.size() == 0);
      e.err   = m_err;
      return e;
   endfunction

   task automatic check(input string name, input exp_t e);
      exp_t a;
      a = actual();
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got cf=%b pf=%b zf=%b cnt=%0d full=%b empty=%b err=%b, expected cf=%b pf=%b zf=%b cnt=%0d full=%b empty=%b err=%b",
                  name, $time, a.cf, a.pf, a.zf, a.cnt, a.full, a.empty, a.err,
                  e.cf, e.pf, e.zf, e.cnt, e.full, e.empty, e.err);
      end
   endtask

   function automatic void model_reset();
      m_cf = 1'b0; m_pf = 1'b0; m_zf = 1'b0; m_err = 1'b0;
      m_stk.delete();
   endfunction

   // Architectural rules: pops restore and win over commit; errors are sticky.
   function automatic void model_step(input stim_t s);
      logic ev, restored;
      logic [2:0] top;
      ev = 1'b0;
      restored = 1'b0;
      if (s.push && s.pop) ev = 1'b1;
      else if (s.push) begin
         if (m_stk.size() == DEPTH) ev = 1'b1;
         else m_stk.push_back({m_zf, m_pf, m_cf});
      end else if (s.pop) begin
         if (m_stk.size() == 0) ev = 1'b1;
         else begin
            top = m_stk.pop_back();
            {m_zf, m_pf, m_cf} = top;
            restored = 1'b1;
         end
      end
      if (!restored && s.we) begin
         if (s.sc_clr) m_cf = 1'b0; else if (s.sc_en) m_cf = s.sc_o;
         if (s.pari_clr) m_pf = 1'b0; else if (s.pari_en) m_pf = s.pari;
         m_zf = (s.rslt == 8'h00);
      end
      if (ev) m_err = 1'b1; else if (s.err_clr) m_err = 1'b0;
   endfunction

   task automatic drive(input stim_t s);
      flag_we = s.we; sc_o = s.sc_o; sc_en = s.sc_en; sc_clr = s.sc_clr;
      pari = s.pari; pari_en = s.pari_en; pari_clr = s.pari_clr; rslt = s.rslt;
      push = s.push; pop = s.pop; err_clr = s.err_clr;
   endtask

   task automatic apply(input stim_t s);
      @(negedge clk);
      drive(s);
      model_step(s);
      exp_q.push_back(model_out());
   endtask

   function automatic stim_t commit(input logic sc_en_v, sc_o_v, sc_clr_v,
                                    pari_en_v, pari_v, pari_clr_v, input logic [7:0] r);
      stim_t s;
      s = '0;
      s.we = 1'b1; s.sc_en = sc_en_v; s.sc_o = sc_o_v; s.sc_clr = sc_clr_v;
      s.pari_en = pari_en_v; s.pari = pari_v; s.pari_clr = pari_clr_v; s.rslt = r;
      return s;
   endfunction

   function automatic stim_t op(input logic pu, po, ec);
      stim_t s;
      s = '0;
      s.push = pu; s.pop = po; s.err_clr = ec;
      return s;
   endfunction

   // Monitor: every applied cycle yields one expected post-edge snapshot.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cycle", e);
         end
      end
   end

   initial begin
      stim_t s;
      exp_t  rst_exp;
      rst_exp = '0;
      rst_exp.empty = 1'b1;

      drive('0);
      rst_n = 1'b0;
      model_reset();
      #12;
      check("reset_state", rst_exp);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic commit, then clear-beats-enable with parity hold
      apply(commit(1, 1, 0, 1, 1, 0, 8'h00));
      apply(commit(1, 1, 1, 0, 0, 0, 8'h5A));

      // No commit: all strobes ignored for three cycles
      s = commit(1, 1, 0, 1, 0, 1, 8'h00);
      s.we = 1'b0;
      repeat (3) apply(s);

      // Save {0,1,1}, change to {1,0,0}, restore while a commit is ignored
      apply(commit(1, 1, 0, 1, 1, 0, 8'h01));
      apply(op(1, 0, 0));
      apply(commit(0, 0, 1, 0, 0, 1, 8'h00));
      s = commit(1, 0, 0, 0, 0, 0, 8'h33);
      s.pop = 1'b1;
      apply(s);

      // Overflow then drain in reverse order, underflow, error clear
      for (int i = 0; i < 5; i++) begin
         s = commit(1, i[0], 0, 1, i[1], 0, (i == 2) ? 8'h00 : 8'h10);
         s.push = 1'b1;
         apply(s);
      end
      repeat (5) apply(op(0, 1, 0));
      apply(op(0, 0, 1));

      // Push and pop together at depth 2
      apply(op(1, 0, 0));
      apply(op(1, 0, 0));
      s = commit(1, 1, 0, 0, 0, 0, 8'h07);
      s.push = 1'b1; s.pop = 1'b1;
      apply(s);
      apply(op(0, 0, 1));

      // Same-cycle error and clear: error wins
      s = op(1, 1, 1);
      apply(s);
      apply(op(0, 0, 1));

      // Asynchronous reset mid-cycle with a push in flight
      apply(op(1, 0, 0));
      @(negedge clk);
      drive(op(1, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_reset", rst_exp);
      drive('0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(op(0, 1, 0));
      apply(op(0, 0, 1));

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         s.we       = ($urandom_range(0, 3) != 0);
         s.sc_o     = 1'($urandom);
         s.sc_en    = 1'($urandom);
         s.sc_clr   = ($urandom_range(0, 3) == 0);
         s.pari     = 1'($urandom);
         s.pari_en  = 1'($urandom);
         s.pari_clr = ($urandom_range(0, 3) == 0);
         s.rslt     = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         s.push     = ($urandom_range(0, 2) == 0);
         s.pop      = ($urandom_range(0, 2) == 0);
         s.err_clr  = ($urandom_range(0, 7) == 0);
         apply(s);
      end
      apply('0);

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
